// File: rtl/rf_pkg.sv
// rf_pkg: definitions shared by the register-file writeback arbiter and its
// busy/forward comparator.
//   XLEN_DEFAULT : default data width of the write port
//   REG_ADDR_W   : register address width
//   ZERO_REG     : hard-wired zero register (x0), never written
//   WAIT_CNT_W   : width of the ALU anti-starvation counter
//   arb_state_e  : arbitration priority state
//   wb_req_t     : one writeback request {valid, rd, data}
package rf_pkg;

  localparam int XLEN_DEFAULT = 64;
  localparam int REG_ADDR_W   = 5;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;
  localparam int WAIT_CNT_W   = 4;

  typedef enum logic {
    PRIO_LSU,
    PRIO_ALU
  } arb_state_e;

  typedef struct packed {
    logic                    valid;
    logic [REG_ADDR_W-1:0]   rd;
    logic [XLEN_DEFAULT-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rf_busy_check.sv
// rf_busy_check: combinational check of one decode source register against
// every write that is in flight.
//   q_rs_i                 : source register being queried
//   alu_valid_i, alu_rd_i  : pending ALU writeback request
//   lsu_valid_i, lsu_rd_i  : pending LSU writeback request
//   rf_we_i, rf_waddr_i    : write currently presented to the register file
//   busy_o                 : source has a write in flight; decode must stall
// With RF_WB_BYPASS_EN defined it also has:
//   rf_wdata_i             : data currently presented to the register file
//   fwd_valid_o/fwd_data_o : the write-stage value can be forwarded
module rf_busy_check
  import rf_pkg::*;
`ifdef RF_WB_BYPASS_EN
#(
  parameter int XLEN = XLEN_DEFAULT
)
`endif
(
  input  logic [REG_ADDR_W-1:0] q_rs_i,
  input  logic                  alu_valid_i,
  input  logic [REG_ADDR_W-1:0] alu_rd_i,
  input  logic                  lsu_valid_i,
  input  logic [REG_ADDR_W-1:0] lsu_rd_i,
  input  logic                  rf_we_i,
  input  logic [REG_ADDR_W-1:0] rf_waddr_i,
`ifdef RF_WB_BYPASS_EN
  input  logic [XLEN-1:0]       rf_wdata_i,
  output logic                  fwd_valid_o,
  output logic [XLEN-1:0]       fwd_data_o,
`endif
  output logic                  busy_o
);

  logic nonZero;
  logic pendHit;
  logic stageHit;

  // x0 always reads as zero, so it can never be waiting on a write.
  assign nonZero  = (q_rs_i != ZERO_REG);
  assign pendHit  = (alu_valid_i && (alu_rd_i == q_rs_i)) ||
                    (lsu_valid_i && (lsu_rd_i == q_rs_i));
  assign stageHit = rf_we_i && (rf_waddr_i == q_rs_i);

`ifdef RF_WB_BYPASS_EN
  // A value sitting in the write stage is forwarded instead of stalling.
  assign fwd_valid_o = nonZero && stageHit;
  assign fwd_data_o  = rf_wdata_i;
  assign busy_o      = nonZero && (pendHit || (stageHit && !fwd_valid_o));
`else
  assign busy_o      = nonZero && (pendHit || stageHit);
`endif

endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the single register-file write port between the ALU
// result path and the LSU load-data path.
//   clk, reset                  : clock, asynchronous active-high reset
//   alu_valid/rd/data, alu_ready: ALU writeback handshake
//   lsu_valid/rd/data, lsu_ready: LSU writeback handshake
//   rf_we, rf_waddr, rf_wdata   : registered register-file write port
//   q_rs1/q_rs2, q_rsN_busy     : decode source queries and stall indication
// Optional feature macro RF_WB_BYPASS_EN adds q_rsN_fwd_valid/q_rsN_fwd_data,
// forwarding the write-stage value to decode.
// LSU normally wins; an ALU request denied MAX_WAIT cycles in a row is given
// priority for one cycle. An accepted request is written one cycle later.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int XLEN     = XLEN_DEFAULT,
  parameter int MAX_WAIT = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [REG_ADDR_W-1:0] lsu_rd,
  input  logic [XLEN-1:0]       lsu_data,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]       rf_wdata,
  input  logic [REG_ADDR_W-1:0] q_rs1,
  input  logic [REG_ADDR_W-1:0] q_rs2,
`ifdef RF_WB_BYPASS_EN
  output logic                  q_rs1_fwd_valid,
  output logic [XLEN-1:0]       q_rs1_fwd_data,
  output logic                  q_rs2_fwd_valid,
  output logic [XLEN-1:0]       q_rs2_fwd_data,
`endif
  output logic                  q_rs1_busy,
  output logic                  q_rs2_busy
);

  // The wait counter is 4 bits wide, so larger limits could never be reached.
  if ((MAX_WAIT < 1) || (MAX_WAIT > 15)) begin : g_bad_max_wait
    $error("rf_wb_arbiter: MAX_WAIT must be in the range 1..15");
  end

  localparam logic [WAIT_CNT_W-1:0] WAIT_LIMIT = WAIT_CNT_W'(MAX_WAIT);

  arb_state_e              state_q, state_d;
  logic [WAIT_CNT_W-1:0]   wait_q, wait_d;
  logic                    rf_we_q, rf_we_d;
  logic [REG_ADDR_W-1:0]   rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0]         rf_wdata_q, rf_wdata_d;

  // Grants are combinational; held low during reset so nothing is accepted.
  always_comb begin
    alu_ready = 1'b0;
    lsu_ready = 1'b0;
    if (!reset) begin
      if (state_q == PRIO_ALU) begin
        alu_ready = alu_valid;
        lsu_ready = lsu_valid && !alu_valid;
      end else begin
        lsu_ready = lsu_valid;
        alu_ready = alu_valid && !lsu_valid;
      end
    end
  end

  // Next state: starvation counter, priority state and the write stage.
  always_comb begin
    wait_d     = wait_q;
    state_d    = state_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;

    if (alu_ready || !alu_valid) begin
      wait_d = '0;
    end else if (wait_q != WAIT_LIMIT) begin
      wait_d = wait_q + WAIT_CNT_W'(1);
    end

    // PRIO_ALU lasts exactly one cycle: the ALU either is accepted or has
    // dropped its request, and both return priority to the LSU.
    if (state_q == PRIO_ALU) begin
      state_d = PRIO_LSU;
    end else if (alu_valid && (wait_d == WAIT_LIMIT)) begin
      state_d = PRIO_ALU;
    end

    // Accepts targeting x0 finish the handshake but never write.
    if (alu_ready) begin
      rf_we_d = (alu_rd != ZERO_REG);
      if (rf_we_d) begin
        rf_waddr_d = alu_rd;
        rf_wdata_d = alu_data;
      end
    end else if (lsu_ready) begin
      rf_we_d = (lsu_rd != ZERO_REG);
      if (rf_we_d) begin
        rf_waddr_d = lsu_rd;
        rf_wdata_d = lsu_data;
      end
    end
  end

  // Asynchronous reset drops any registered write immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= PRIO_LSU;
      wait_q     <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

  rf_busy_check
`ifdef RF_WB_BYPASS_EN
    #(.XLEN(XLEN))
`endif
  u_rs1_check (
    .q_rs_i      (q_rs1),
    .alu_valid_i (alu_valid),
    .alu_rd_i    (alu_rd),
    .lsu_valid_i (lsu_valid),
    .lsu_rd_i    (lsu_rd),
    .rf_we_i     (rf_we_q),
    .rf_waddr_i  (rf_waddr_q),
`ifdef RF_WB_BYPASS_EN
    .rf_wdata_i  (rf_wdata_q),
    .fwd_valid_o (q_rs1_fwd_valid),
    .fwd_data_o  (q_rs1_fwd_data),
`endif
    .busy_o      (q_rs1_busy)
  );

  rf_busy_check
`ifdef RF_WB_BYPASS_EN
    #(.XLEN(XLEN))
`endif
  u_rs2_check (
    .q_rs_i      (q_rs2),
    .alu_valid_i (alu_valid),
    .alu_rd_i    (alu_rd),
    .lsu_valid_i (lsu_valid),
    .lsu_rd_i    (lsu_rd),
    .rf_we_i     (rf_we_q),
    .rf_waddr_i  (rf_waddr_q),
`ifdef RF_WB_BYPASS_EN
    .rf_wdata_i  (rf_wdata_q),
    .fwd_valid_o (q_rs2_fwd_valid),
    .fwd_data_o  (q_rs2_fwd_data),
`endif
    .busy_o      (q_rs2_busy)
  );

endmodule
